// File: rtl/mdu_ctrl.sv
// Multiply/divide unit controller: a mult/div is accepted in IDLE, its result is held in phi/plo,
// and HI/LO update after MULT_CYC/DIV_CYC busy cycles; D-stage MD instructions stall while busy.
module mdu_ctrl #(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        d_is_md,
  output logic        start,
  output logic        busy,
  output logic        stall,
  output logic [31:0] rdata,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYC = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
  localparam int CW      = $clog2(MAX_CYC + 1);
  localparam logic [CW-1:0] MULT_N = CW'(MULT_CYC);
  localparam logic [CW-1:0] DIV_N  = CW'(DIV_CYC);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;

  typedef enum logic {S_IDLE, S_BUSY} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   phi_q, phi_d, plo_q, plo_d;
  logic [31:0]   hi_q, hi_d, lo_q, lo_d;

  logic [63:0] prod_s, prod_u;
  logic        div_signed, rs_neg, rt_neg;
  logic [31:0] a_mag, b_mag, b_safe, q_mag, r_mag, quot, rem;

  assign prod_s = {{32{rs_data[31]}}, rs_data} * {{32{rt_data[31]}}, rt_data};
  assign prod_u = {32'd0, rs_data} * {32'd0, rt_data};

  // Divide on magnitudes so 0x80000000 / -1 wraps cleanly instead of overflowing a signed divide.
  assign div_signed = (op == OP_DIV);
  assign rs_neg     = div_signed & rs_data[31];
  assign rt_neg     = div_signed & rt_data[31];
  assign a_mag      = rs_neg ? (32'd0 - rs_data) : rs_data;
  assign b_mag      = rt_neg ? (32'd0 - rt_data) : rt_data;
  assign b_safe     = (b_mag == 32'd0) ? 32'd1 : b_mag;
  assign q_mag      = a_mag / b_safe;
  assign r_mag      = a_mag % b_safe;
  assign quot       = (rs_neg ^ rt_neg) ? (32'd0 - q_mag) : q_mag;
  assign rem        = rs_neg ? (32'd0 - r_mag) : r_mag;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    phi_d   = phi_q;
    plo_d   = plo_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    start   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        case (op)
          OP_MULT, OP_MULTU: begin
            start   = 1'b1;
            state_d = S_BUSY;
            cnt_d   = MULT_N;
            phi_d   = (op == OP_MULT) ? prod_s[63:32] : prod_u[63:32];
            plo_d   = (op == OP_MULT) ? prod_s[31:0]  : prod_u[31:0];
          end
          OP_DIV, OP_DIVU: begin
            start   = 1'b1;
            state_d = S_BUSY;
            cnt_d   = DIV_N;
            // A zero divisor re-commits the current HI/LO so they appear unchanged.
            phi_d   = (rt_data == 32'd0) ? hi_q : rem;
            plo_d   = (rt_data == 32'd0) ? lo_q : quot;
          end
          OP_MTHI: hi_d = rs_data;
          OP_MTLO: lo_d = rs_data;
          default: ;
        endcase
      end
      S_BUSY: begin
        if (cnt_q == CW'(1)) begin
          hi_d    = phi_q;
          lo_d    = plo_q;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      phi_q   <= '0;
      plo_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      phi_q   <= phi_d;
      plo_q   <= plo_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy  = (state_q == S_BUSY);
  assign stall = d_is_md & (start | busy);
  assign hi    = hi_q;
  assign lo    = lo_q;
  assign rdata = (op == OP_MFHI) ? hi_q :
                 (op == OP_MFLO) ? lo_q : 32'd0;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl: each task drives one scenario and compares against hand-computed values.
module tb_mdu_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  op;
  logic [31:0] rs_data, rt_data;
  logic        d_is_md;
  logic        start, busy, stall;
  logic [31:0] rdata, hi, lo;

  int total = 0;
  int bad   = 0;

  mdu_ctrl #(.MULT_CYC(5), .DIV_CYC(10)) dut (
    .clk(clk), .reset(reset), .op(op), .rs_data(rs_data), .rt_data(rt_data),
    .d_is_md(d_is_md), .start(start), .busy(busy), .stall(stall),
    .rdata(rdata), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; op = 4'd0; rs_data = 32'd0; rt_data = 32'd0; d_is_md = 1'b0;
    tick(); tick();
    settle();
    total++; if (start !== 1'b0) begin bad++; $display("FAIL reset_start got=%0b exp=0", start); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%0b exp=0", stall); end
    total++; if (rdata !== 32'd0) begin bad++; $display("FAIL reset_rdata got=%h exp=0", rdata); end
    total++; if (hi !== 32'd0) begin bad++; $display("FAIL reset_hi got=%h exp=0", hi); end
    total++; if (lo !== 32'd0) begin bad++; $display("FAIL reset_lo got=%h exp=0", lo); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_mult();
    logic [3:0]  t_op [2] = '{4'd1, 4'd2};
    logic [31:0] t_hi [2] = '{32'hFFFFFFFF, 32'h00000002};
    logic [31:0] t_lo [2] = '{32'hFFFFFFFA, 32'hFFFFFFFA};
    for (int k = 0; k < 2; k++) begin
      op = t_op[k]; rs_data = 32'hFFFFFFFE; rt_data = 32'd3; d_is_md = 1'b0;
      settle();
      total++; if (start !== 1'b1) begin bad++; $display("FAIL mult%0d_start got=%0b exp=1", k, start); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL mult%0d_busy_start got=%0b exp=0", k, busy); end
      tick();
      op = 4'd0;
      for (int i = 0; i < 5; i++) begin
        settle();
        total++; if (busy !== 1'b1 || start !== 1'b0) begin
          bad++; $display("FAIL mult%0d_busy_cyc%0d got busy=%0b start=%0b exp busy=1 start=0", k, i, busy, start);
        end
        tick();
      end
      settle();
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL mult%0d_busy_end got=%0b exp=0", k, busy); end
      total++; if (hi !== t_hi[k]) begin bad++; $display("FAIL mult%0d_hi got=%h exp=%h", k, hi, t_hi[k]); end
      total++; if (lo !== t_lo[k]) begin bad++; $display("FAIL mult%0d_lo got=%h exp=%h", k, lo, t_lo[k]); end
      tick();
    end
  endtask

  task automatic test_div();
    logic [3:0]  t_op [4] = '{4'd3, 4'd4, 4'd3, 4'd4};
    logic [31:0] t_rs [4] = '{32'hFFFFFFF9, 32'd7, 32'h80000000, 32'd100};
    logic [31:0] t_rt [4] = '{32'd2, 32'd0, 32'hFFFFFFFF, 32'd7};
    logic [31:0] t_hi [4] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'd2};
    logic [31:0] t_lo [4] = '{32'hFFFFFFFD, 32'hFFFFFFFD, 32'h80000000, 32'd14};
    for (int k = 0; k < 4; k++) begin
      op = t_op[k]; rs_data = t_rs[k]; rt_data = t_rt[k]; d_is_md = 1'b0;
      settle();
      total++; if (start !== 1'b1) begin bad++; $display("FAIL div%0d_start got=%0b exp=1", k, start); end
      tick();
      op = 4'd0;
      for (int i = 0; i < 10; i++) begin
        settle();
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL div%0d_busy_cyc%0d got=%0b exp=1", k, i, busy); end
        tick();
      end
      settle();
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL div%0d_busy_end got=%0b exp=0", k, busy); end
      total++; if (hi !== t_hi[k]) begin bad++; $display("FAIL div%0d_hi got=%h exp=%h", k, hi, t_hi[k]); end
      total++; if (lo !== t_lo[k]) begin bad++; $display("FAIL div%0d_lo got=%h exp=%h", k, lo, t_lo[k]); end
      tick();
    end
  endtask

  task automatic test_stall();
    op = 4'd1; rs_data = 32'd5; rt_data = 32'd6; d_is_md = 1'b1;
    settle();
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL stall_start got=%0b exp=1", stall); end
    tick();
    op = 4'd0;
    for (int i = 0; i < 5; i++) begin
      settle();
      total++; if (stall !== 1'b1) begin bad++; $display("FAIL stall_busy_cyc%0d got=%0b exp=1", i, stall); end
      tick();
    end
    settle();
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL stall_release got=%0b exp=0", stall); end
    total++; if (lo !== 32'd30) begin bad++; $display("FAIL stall_lo got=%h exp=%h", lo, 32'd30); end
    tick();
    op = 4'd2; rs_data = 32'd1; rt_data = 32'd1; d_is_md = 1'b0;
    settle();
    total++; if (stall !== 1'b0 || start !== 1'b1) begin
      bad++; $display("FAIL nostall_start got stall=%0b start=%0b exp stall=0 start=1", stall, start);
    end
    tick();
    op = 4'd0;
    for (int i = 0; i < 5; i++) begin
      settle();
      total++; if (stall !== 1'b0 || busy !== 1'b1) begin
        bad++; $display("FAIL nostall_cyc%0d got stall=%0b busy=%0b exp stall=0 busy=1", i, stall, busy);
      end
      tick();
    end
    settle();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL nostall_end got=%0b exp=0", busy); end
    tick();
  endtask

  task automatic test_back_to_back();
    // hi=0, lo=1 from the preceding multu 1*1.
    op = 4'd1; rs_data = 32'd3; rt_data = 32'd4; d_is_md = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      op = (i % 2 == 1) ? 4'd5 : 4'd3; rs_data = 32'hDEADBEEF; rt_data = 32'd2;
      settle();
      total++; if (start !== 1'b0 || stall !== 1'b1 || busy !== 1'b1) begin
        bad++; $display("FAIL b2b_busy_cyc%0d got start=%0b stall=%0b busy=%0b exp 0 1 1", i, start, stall, busy);
      end
      total++; if (hi !== 32'd0 || lo !== 32'd1) begin
        bad++; $display("FAIL b2b_hold_cyc%0d got hi=%h lo=%h exp hi=0 lo=1", i, hi, lo);
      end
      tick();
    end
    op = 4'd3; rs_data = 32'd9; rt_data = 32'd2;
    settle();
    total++; if (busy !== 1'b0 || start !== 1'b1 || stall !== 1'b1) begin
      bad++; $display("FAIL b2b_second_accept got busy=%0b start=%0b stall=%0b exp 0 1 1", busy, start, stall);
    end
    total++; if (hi !== 32'd0 || lo !== 32'd12) begin
      bad++; $display("FAIL b2b_first_result got hi=%h lo=%h exp hi=0 lo=c", hi, lo);
    end
    tick();
    op = 4'd0; d_is_md = 1'b0;
    repeat (10) tick();
    settle();
    total++; if (busy !== 1'b0 || hi !== 32'd1 || lo !== 32'd4) begin
      bad++; $display("FAIL b2b_second_result got busy=%0b hi=%h lo=%h exp busy=0 hi=1 lo=4", busy, hi, lo);
    end
    tick();
  endtask

  task automatic test_mthi();
    op = 4'd5; rs_data = 32'h12345678; d_is_md = 1'b0;
    tick();
    op = 4'd6; rs_data = 32'hCAFEF00D;
    tick();
    op = 4'd7;
    settle();
    total++; if (rdata !== 32'h12345678) begin bad++; $display("FAIL mfhi_rdata got=%h exp=12345678", rdata); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mthi_busy got=%0b exp=0", busy); end
    op = 4'd8; #1;
    total++; if (rdata !== 32'hCAFEF00D) begin bad++; $display("FAIL mflo_rdata got=%h exp=cafef00d", rdata); end
    op = 4'd0; #1;
    total++; if (rdata !== 32'd0) begin bad++; $display("FAIL none_rdata got=%h exp=0", rdata); end
    op = 4'd12; #1;
    total++; if (rdata !== 32'd0 || start !== 1'b0) begin
      bad++; $display("FAIL op12 got rdata=%h start=%0b exp rdata=0 start=0", rdata, start);
    end
    op = 4'd0;
    tick();
  endtask

  task automatic test_reset_mid_div();
    op = 4'd3; rs_data = 32'd100; rt_data = 32'd7; d_is_md = 1'b0;
    tick();
    op = 4'd0;
    repeat (3) tick();
    reset = 1'b1;
    settle();
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL rstdiv_pre_busy got=%0b exp=1", busy); end
    tick();
    reset = 1'b0;
    settle();
    total++; if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      bad++; $display("FAIL rstdiv_after got busy=%0b hi=%h lo=%h exp 0 0 0", busy, hi, lo);
    end
    repeat (12) tick();
    settle();
    total++; if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      bad++; $display("FAIL rstdiv_later got busy=%0b hi=%h lo=%h exp 0 0 0", busy, hi, lo);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_stall();
    test_back_to_back();
    test_mthi();
    test_reset_mid_div();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
